// File: rtl/pio_frame_pkg.sv
// Shared codes for the PIO frame bridge: software commands, status replies and FSM states.
package pio_frame_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_ABORT = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_ACK   = 2'b01,
        ST_BUSY  = 2'b10,
        ST_ERROR = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ACK,
        S_DELIVER,
        S_TX_WAIT,
        S_RD_ACK,
        S_ABORT,
        S_ERR
    } state_e;

endpackage

// File: rtl/pio_frame_reg.sv
// Frame register with word-indexed write, parallel load and word-indexed read mux.
// Word 0 sits in the most significant WORD_W bits.
module pio_frame_reg #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned PTR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          we_i,
    input  logic [PTR_W-1:0]              wr_ptr_i,
    input  logic [WORD_W-1:0]             word_i,
    input  logic                          load_i,
    input  logic [WORD_W*NUM_WORDS-1:0]   frame_i,
    input  logic [PTR_W-1:0]              rd_ptr_i,
    output logic [WORD_W*NUM_WORDS-1:0]   frame_o,
    output logic [WORD_W-1:0]             rd_word_o
);

    localparam int unsigned FRAME_W = WORD_W * NUM_WORDS;

    logic [FRAME_W-1:0] frame_q, frame_d;

    always_comb begin
        frame_d = frame_q;
        if (load_i) begin
            frame_d = frame_i;
        end else if (we_i) begin
            for (int unsigned k = 0; k < NUM_WORDS; k++) begin
                if (wr_ptr_i == PTR_W'(k)) begin
                    frame_d[FRAME_W-1-k*WORD_W -: WORD_W] = word_i;
                end
            end
        end
    end

    always_comb begin
        rd_word_o = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (rd_ptr_i == PTR_W'(k)) begin
                rd_word_o = frame_q[FRAME_W-1-k*WORD_W -: WORD_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_o = frame_q;

endmodule

// File: rtl/pio_frame_bridge.sv
// Hardware endpoint of the PIO mailbox: assembles software words into an rx frame for the
// core and returns the core's result frame to software word by word.
module pio_frame_bridge
    import pio_frame_pkg::*;
#(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned NUM_WORDS = 16
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [WORD_W-1:0]           to_hw_port_wire_export,
    input  logic [1:0]                  to_hw_sig_wire_export,
    output logic [WORD_W-1:0]           to_sw_port_wire_export,
    output logic [1:0]                  to_sw_sig_wire_export,
    output logic [WORD_W*NUM_WORDS-1:0] rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready
);

    localparam int unsigned FRAME_W = WORD_W * NUM_WORDS;
    localparam int unsigned PTR_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_WORDS - 1);

    cmd_e              cmd_q;
    logic [WORD_W-1:0] port_q;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              tx_loaded_q, tx_loaded_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ready_q, tx_ready_d;
    status_e           sts_q, sts_d;
    logic [WORD_W-1:0] out_q, out_d;

    logic              rx_we;
    logic              tx_load;
    logic [WORD_W-1:0] tx_word;
    logic [WORD_W-1:0] rx_word_unused;
    logic [FRAME_W-1:0] tx_frame_unused;

    pio_frame_reg #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .PTR_W    (PTR_W)
    ) u_rx_frame (
        .clk_i    (clk_clk),
        .rst_ni   (reset_reset_n),
        .we_i     (rx_we),
        .wr_ptr_i (wr_ptr_q),
        .word_i   (port_q),
        .load_i   (1'b0),
        .frame_i  ('0),
        .rd_ptr_i (wr_ptr_q),
        .frame_o  (rx_data),
        .rd_word_o(rx_word_unused)
    );

    pio_frame_reg #(
        .WORD_W   (WORD_W),
        .NUM_WORDS(NUM_WORDS),
        .PTR_W    (PTR_W)
    ) u_tx_frame (
        .clk_i    (clk_clk),
        .rst_ni   (reset_reset_n),
        .we_i     (1'b0),
        .wr_ptr_i ('0),
        .word_i   ('0),
        .load_i   (tx_load),
        .frame_i  (tx_data),
        .rd_ptr_i (rd_ptr_q),
        .frame_o  (tx_frame_unused),
        .rd_word_o(tx_word)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tx_loaded_d = tx_loaded_q;
        rx_valid_d  = rx_valid_q;
        tx_ready_d  = tx_ready_q;
        sts_d       = sts_q;
        out_d       = out_q;
        rx_we       = 1'b0;
        tx_load     = 1'b0;

        if (cmd_q == CMD_ABORT) begin
            state_d     = S_ABORT;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            tx_loaded_d = 1'b0;
            rx_valid_d  = 1'b0;
            tx_ready_d  = 1'b0;
            sts_d       = ST_ERROR;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_q == CMD_WRITE) begin
                        rx_we   = 1'b1;
                        sts_d   = ST_ACK;
                        state_d = S_WR_ACK;
                    end else if (cmd_q == CMD_READ) begin
                        if (tx_loaded_q) begin
                            out_d   = tx_word;
                            sts_d   = ST_ACK;
                            state_d = S_RD_ACK;
                        end else begin
                            sts_d      = ST_BUSY;
                            tx_ready_d = 1'b1;
                            state_d    = S_TX_WAIT;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (cmd_q == CMD_IDLE) begin
                        if (wr_ptr_q == LAST_PTR) begin
                            wr_ptr_d   = '0;
                            rx_valid_d = 1'b1;
                            sts_d      = ST_BUSY;
                            state_d    = S_DELIVER;
                        end else begin
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                            sts_d    = ST_READY;
                            state_d  = S_IDLE;
                        end
                    end else if (cmd_q == CMD_READ) begin
                        sts_d   = ST_ERROR;
                        state_d = S_ERR;
                    end
                end
                S_DELIVER: begin
                    if (rx_valid_q && rx_ready) begin
                        rx_valid_d = 1'b0;
                        sts_d      = ST_READY;
                        state_d    = S_IDLE;
                    end
                end
                // Load and present take two cycles so the read mux sees the latched frame.
                S_TX_WAIT: begin
                    if (tx_loaded_q) begin
                        out_d   = tx_word;
                        sts_d   = ST_ACK;
                        state_d = S_RD_ACK;
                    end else if (tx_ready_q && tx_valid) begin
                        tx_load     = 1'b1;
                        tx_loaded_d = 1'b1;
                        tx_ready_d  = 1'b0;
                    end
                end
                S_RD_ACK: begin
                    if (cmd_q == CMD_IDLE) begin
                        if (rd_ptr_q == LAST_PTR) begin
                            rd_ptr_d    = '0;
                            tx_loaded_d = 1'b0;
                        end else begin
                            rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        end
                        sts_d   = ST_READY;
                        state_d = S_IDLE;
                    end else if (cmd_q == CMD_WRITE) begin
                        sts_d   = ST_ERROR;
                        state_d = S_ERR;
                    end
                end
                S_ABORT: begin
                    if (cmd_q == CMD_IDLE) begin
                        sts_d   = ST_READY;
                        state_d = S_IDLE;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd_q       <= CMD_IDLE;
            port_q      <= '0;
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tx_loaded_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            sts_q       <= ST_READY;
            out_q       <= '0;
        end else begin
            cmd_q       <= cmd_e'(to_hw_sig_wire_export);
            port_q      <= to_hw_port_wire_export;
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tx_loaded_q <= tx_loaded_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            sts_q       <= sts_d;
            out_q       <= out_d;
        end
    end

    assign to_sw_port_wire_export = out_q;
    assign to_sw_sig_wire_export  = sts_q;
    assign rx_valid               = rx_valid_q;
    assign tx_ready               = tx_ready_q;

endmodule
